// File: rtl/decoder_scan_ctrl.sv
// -----------------------------------------------------------------------------
// decoder_scan_ctrl
//
// Purpose:
//   Steps a 3-bit select code through 0..7 at a programmable rate and drives
//   the matching one-hot 3-to-8 decode. Intended for scanning LED banks or
//   digit enables. Supports start / stop / hold control, up/down direction,
//   preload of the select value, and a one-cycle wrap indication.
//
// Optional feature (macro BOUNCE_MODE_EN):
//   When defined, bounce=1 makes the scan ping-pong 0..7..0 using an internal
//   direction flag. When undefined, the bounce input is accepted but ignored.
//
// Parameters:
//   CNT_W    width of the step prescaler
//   CNT_MAX  step period minus one, in sys_clk cycles (0 = step every clock)
//
// Ports:
//   sys_clk    in   system clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   start      in   pulse: start or resume scanning
//   stop       in   pulse: pause (RUN->HOLD) or return to idle (HOLD->IDLE)
//   dir        in   0 = up, 1 = down; sampled at each step
//   bounce     in   ping-pong request (only with BOUNCE_MODE_EN)
//   sel_load   in   load sel_init into the select register (IDLE/HOLD only)
//   sel_init   in   preload value
//   sel        out  current select code (registered)
//   dec_out    out  one-hot decode of sel
//   busy       out  high while in RUN
//   wrap       out  one-cycle pulse aligned with a wrap / turnaround value
//
// Control inputs are level-sampled on each rising edge; start, stop and
// sel_load are expected as single-cycle pulses. stop has priority over start.
// -----------------------------------------------------------------------------
module decoder_scan_ctrl #(
    parameter int              CNT_W   = 24,
    parameter logic [CNT_W-1:0] CNT_MAX = 24'd9_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       dir,
    input  logic       bounce,
    input  logic       sel_load,
    input  logic [2:0] sel_init,
    output logic [2:0] sel,
    output logic [7:0] dec_out,
    output logic       busy,
    output logic       wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [2:0]       sel_q, sel_d;
    logic             wrap_q, wrap_d;

    // Result of taking one step from the current select value.
    logic             go_down;
    logic [2:0]       step_sel;
    logic             step_wrap;

`ifdef BOUNCE_MODE_EN
    // Internal ping-pong direction: 0 = heading up, 1 = heading down.
    logic             down_q, down_d;
    logic             step_down;
`else
    logic             unused_bounce;
    assign unused_bounce = bounce;
`endif

    // ---------------------------------------------------------------- step
    always_comb begin
        go_down   = dir;
`ifdef BOUNCE_MODE_EN
        step_down = down_q;
        if (bounce) begin
            // Turn around at the ends, including when bounce is entered
            // sitting at 7 while heading up (or at 0 heading down).
            go_down = down_q ? (sel_q != 3'd0) : (sel_q == 3'd7);
        end
`endif
        step_sel = go_down ? (sel_q - 3'd1) : (sel_q + 3'd1);
        // Modulo-8 wrap: up lands on 0, down lands on 7.
        step_wrap = go_down ? (step_sel == 3'd7) : (step_sel == 3'd0);
`ifdef BOUNCE_MODE_EN
        if (bounce) begin
            step_wrap = (step_sel == 3'd7) || (step_sel == 3'd0);
            if (step_sel == 3'd7)      step_down = 1'b1;
            else if (step_sel == 3'd0) step_down = 1'b0;
            else                       step_down = go_down;
        end
`endif
    end

    // ------------------------------------------------------ next state
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sel_d   = sel_q;
        wrap_d  = 1'b0;
`ifdef BOUNCE_MODE_EN
        down_d  = down_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (sel_load) sel_d = sel_init;
                if (start && !stop) begin
                    state_d = RUN;
                    presc_d = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    // Freeze everything; a step due this cycle is dropped.
                    state_d = HOLD;
                end else if (presc_q == CNT_MAX) begin
                    presc_d = '0;
                    sel_d   = step_sel;
                    wrap_d  = step_wrap;
`ifdef BOUNCE_MODE_EN
                    down_d  = step_down;
`endif
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                    sel_d   = 3'd0;
                    presc_d = '0;
`ifdef BOUNCE_MODE_EN
                    down_d  = 1'b0;
`endif
                end else begin
                    if (sel_load) sel_d = sel_init;
                    // Resume keeps the frozen prescaler phase.
                    if (start) state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                presc_d = '0;
                sel_d   = 3'd0;
            end
        endcase
    end

    // ------------------------------------------------------- registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            sel_q   <= 3'd0;
            wrap_q  <= 1'b0;
`ifdef BOUNCE_MODE_EN
            down_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            sel_q   <= sel_d;
            wrap_q  <= wrap_d;
`ifdef BOUNCE_MODE_EN
            down_q  <= down_d;
`endif
        end
    end

    // ---------------------------------------------------------- outputs
    assign sel     = sel_q;
    assign dec_out = 8'h01 << sel_q;
    assign busy    = (state_q == RUN);
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_decoder_scan_ctrl
//
// Directed bench for decoder_scan_ctrl. Two instances share clock and reset:
//   dut  : CNT_MAX = 3 (step every 4 clocks)
//   zdut : CNT_MAX = 0 (step every clock), used for the fast / bounce scan
// Inputs are driven 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_decoder_scan_ctrl;

    logic       sys_clk;
    logic       sys_rst_n;

    logic       start, stop, dir, bounce, sel_load;
    logic [2:0] sel_init;
    logic [2:0] sel;
    logic [7:0] dec_out;
    logic       busy, wrap;

    logic       z_start, z_stop, z_dir, z_bounce, z_sel_load;
    logic [2:0] z_sel_init;
    logic [2:0] z_sel;
    logic [7:0] z_dec_out;
    logic       z_busy, z_wrap;

    int n_tests;
    int n_fail;

    decoder_scan_ctrl #(.CNT_W(24), .CNT_MAX(24'd3)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .stop      (stop),
        .dir       (dir),
        .bounce    (bounce),
        .sel_load  (sel_load),
        .sel_init  (sel_init),
        .sel       (sel),
        .dec_out   (dec_out),
        .busy      (busy),
        .wrap      (wrap)
    );

    decoder_scan_ctrl #(.CNT_W(24), .CNT_MAX(24'd0)) zdut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (z_start),
        .stop      (z_stop),
        .dir       (z_dir),
        .bounce    (z_bounce),
        .sel_load  (z_sel_load),
        .sel_init  (z_sel_init),
        .sel       (z_sel),
        .dec_out   (z_dec_out),
        .busy      (z_busy),
        .wrap      (z_wrap)
    );

    // ------------------------------------------------ clock / reset
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    // ------------------------------------------------------- tests
    task automatic test_reset;
        logic [7:0] edec;
        edec = 8'h01;
        if ({sel, dec_out, busy, wrap} !== {3'd0, edec, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_dut: got sel=%0d dec=%h busy=%b wrap=%b, exp sel=0 dec=01 busy=0 wrap=0",
                     sel, dec_out, busy, wrap);
        end
        n_tests++;
        if ({z_sel, z_dec_out, z_busy, z_wrap} !== {3'd0, edec, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_zdut: got sel=%0d dec=%h busy=%b wrap=%b, exp sel=0 dec=01 busy=0 wrap=0",
                     z_sel, z_dec_out, z_busy, z_wrap);
        end
        n_tests++;
    endtask

    // Up scan 0..7..0 with a step every 4 clocks; wrap on 7->0.
    task automatic test_up_scan;
        logic [2:0] es;
        logic       ew;
        logic [7:0] edec;
        dir = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) tick();
            // k clocks after entering RUN: sel = floor(k/4) mod 8
            es   = 3'((k / 4) % 8);
            ew   = (k == 32);
            edec = 8'h01 << es;
            if ({sel, dec_out, busy, wrap} !== {es, edec, 1'b1, ew}) begin
                n_fail++;
                $display("FAIL up_scan[%0d]: got sel=%0d dec=%h busy=%b wrap=%b, exp sel=%0d dec=%h busy=1 wrap=%b",
                         k, sel, dec_out, busy, wrap, es, edec, ew);
            end
            n_tests++;
        end
    endtask

    // dir=1 from sel=0: 0 -> 7 (wrap) -> 6 -> 5.
    task automatic test_dir_down;
        logic [2:0] es;
        logic       ew;
        logic [7:0] edec;
        dir = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            es   = (c < 3) ? 3'd0 : (c < 7) ? 3'd7 : (c < 11) ? 3'd6 : 3'd5;
            ew   = (c == 3);
            edec = 8'h01 << es;
            if ({sel, dec_out, busy, wrap} !== {es, edec, 1'b1, ew}) begin
                n_fail++;
                $display("FAIL dir_down[%0d]: got sel=%0d dec=%h busy=%b wrap=%b, exp sel=%0d dec=%h busy=1 wrap=%b",
                         c, sel, dec_out, busy, wrap, es, edec, ew);
            end
            n_tests++;
        end
    endtask

    // Stop two clocks into a period, resume keeps the phase, stop twice -> IDLE.
    task automatic test_hold_resume;
        // {start, stop, exp_sel, exp_busy}
        logic [5:0] vec [10];
        logic [2:0] es;
        logic       eb;
        logic [7:0] edec;
        vec = '{ {1'b0,1'b0,3'd5,1'b1}, {1'b0,1'b0,3'd5,1'b1},
                 {1'b0,1'b1,3'd5,1'b0}, {1'b0,1'b0,3'd5,1'b0},
                 {1'b0,1'b0,3'd5,1'b0}, {1'b1,1'b0,3'd5,1'b1},
                 {1'b0,1'b0,3'd5,1'b1}, {1'b0,1'b0,3'd4,1'b1},
                 {1'b0,1'b1,3'd4,1'b0}, {1'b0,1'b1,3'd0,1'b0} };
        for (int i = 0; i < 10; i++) begin
            start = vec[i][5];
            stop  = vec[i][4];
            tick();
            start = 1'b0;
            stop  = 1'b0;
            es   = vec[i][3:1];
            eb   = vec[i][0];
            edec = 8'h01 << es;
            if ({sel, dec_out, busy, wrap} !== {es, edec, eb, 1'b0}) begin
                n_fail++;
                $display("FAIL hold_resume[%0d]: got sel=%0d dec=%h busy=%b wrap=%b, exp sel=%0d dec=%h busy=%b wrap=0",
                         i, sel, dec_out, busy, wrap, es, edec, eb);
            end
            n_tests++;
        end
    endtask

    // Preload, start+stop priority, load ignored in RUN, load+start in HOLD,
    // and a stop that coincides with a due step.
    task automatic test_load;
        // {start, stop, sel_load, sel_init, exp_sel, exp_busy}
        logic [9:0] vec [18];
        logic [2:0] es;
        logic       eb;
        logic [7:0] edec;
        dir = 1'b0;
        vec = '{ {3'b001,3'd5,3'd5,1'b0},   // IDLE load 5
                 {3'b110,3'd0,3'd5,1'b0},   // start+stop: stay IDLE
                 {3'b010,3'd0,3'd5,1'b0},   // stop ignored in IDLE
                 {3'b100,3'd0,3'd5,1'b1},   // RUN, presc 0
                 {3'b001,3'd2,3'd5,1'b1},   // load ignored in RUN, presc 1
                 {3'b010,3'd0,3'd5,1'b0},   // HOLD, presc 1
                 {3'b101,3'd3,3'd3,1'b1},   // load + start from HOLD
                 {3'b000,3'd0,3'd3,1'b1},   // presc 2
                 {3'b000,3'd0,3'd3,1'b1},   // presc 3
                 {3'b000,3'd0,3'd4,1'b1},   // step
                 {3'b000,3'd0,3'd4,1'b1},
                 {3'b000,3'd0,3'd4,1'b1},
                 {3'b000,3'd0,3'd4,1'b1},   // presc 3, step due next
                 {3'b010,3'd0,3'd4,1'b0},   // stop wins, step dropped
                 {3'b100,3'd0,3'd4,1'b1},   // resume at presc 3
                 {3'b000,3'd0,3'd5,1'b1},   // step immediately
                 {3'b010,3'd0,3'd5,1'b0},   // HOLD
                 {3'b010,3'd0,3'd0,1'b0} }; // IDLE
        for (int i = 0; i < 18; i++) begin
            start    = vec[i][9];
            stop     = vec[i][8];
            sel_load = vec[i][7];
            sel_init = vec[i][6:4];
            tick();
            start    = 1'b0;
            stop     = 1'b0;
            sel_load = 1'b0;
            es   = vec[i][3:1];
            eb   = vec[i][0];
            edec = 8'h01 << es;
            if ({sel, dec_out, busy, wrap} !== {es, edec, eb, 1'b0}) begin
                n_fail++;
                $display("FAIL load[%0d]: got sel=%0d dec=%h busy=%b wrap=%b, exp sel=%0d dec=%h busy=%b wrap=0",
                         i, sel, dec_out, busy, wrap, es, edec, eb);
            end
            n_tests++;
        end
    endtask

    // CNT_MAX=0 scan with bounce=1: ping-pong when the feature is built in,
    // otherwise a plain up scan.
    task automatic test_fast_scan;
        logic [2:0] seq [16];
        logic [2:0] es;
        logic       ew;
        logic       eb;
        logic [7:0] edec;
`ifdef BOUNCE_MODE_EN
        seq = '{3'd1,3'd2,3'd3,3'd4,3'd5,3'd6,3'd7,3'd6,
                3'd5,3'd4,3'd3,3'd2,3'd1,3'd0,3'd1,3'd2};
`else
        seq = '{3'd1,3'd2,3'd3,3'd4,3'd5,3'd6,3'd7,3'd0,
                3'd1,3'd2,3'd3,3'd4,3'd5,3'd6,3'd7,3'd0};
`endif
        z_dir    = 1'b0;
        z_bounce = 1'b1;
        z_start  = 1'b1;
        tick();
        z_start  = 1'b0;
        es = 3'd0;
        for (int i = 0; i < 19; i++) begin
            if (i > 0) begin
                if (i >= 17) z_stop = 1'b1;
                tick();
                z_stop = 1'b0;
            end
            ew = 1'b0;
            eb = 1'b1;
            if (i >= 1 && i <= 16) begin
                es = seq[i-1];
`ifdef BOUNCE_MODE_EN
                ew = (es == 3'd7) || (es == 3'd0);
`else
                ew = (es == 3'd0);
`endif
            end else if (i == 17) begin
                eb = 1'b0;          // stop wins over the due step
            end else if (i == 18) begin
                es = 3'd0;          // second stop: back to IDLE
                eb = 1'b0;
            end
            edec = 8'h01 << es;
            if ({z_sel, z_dec_out, z_busy, z_wrap} !== {es, edec, eb, ew}) begin
                n_fail++;
                $display("FAIL fast_scan[%0d]: got sel=%0d dec=%h busy=%b wrap=%b, exp sel=%0d dec=%h busy=%b wrap=%b",
                         i, z_sel, z_dec_out, z_busy, z_wrap, es, edec, eb, ew);
            end
            n_tests++;
        end
        z_bounce = 1'b0;
    endtask

    // Asynchronous reset in the middle of RUN with sel=4.
    task automatic test_async_reset;
        logic [7:0] edec;
        dir      = 1'b0;
        sel_load = 1'b1;
        sel_init = 3'd4;
        start    = 1'b1;
        tick();
        sel_load = 1'b0;
        start    = 1'b0;
        tick();
        edec = 8'h10;
        if ({sel, dec_out, busy} !== {3'd4, edec, 1'b1}) begin
            n_fail++;
            $display("FAIL pre_reset_run: got sel=%0d dec=%h busy=%b, exp sel=4 dec=10 busy=1",
                     sel, dec_out, busy);
        end
        n_tests++;
        #2;
        sys_rst_n = 1'b0;
        #1;
        edec = 8'h01;
        if ({sel, dec_out, busy, wrap} !== {3'd0, edec, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got sel=%0d dec=%h busy=%b wrap=%b, exp sel=0 dec=01 busy=0 wrap=0",
                     sel, dec_out, busy, wrap);
        end
        n_tests++;
        tick();
        sys_rst_n = 1'b1;
        tick();
        tick();
        if ({sel, dec_out, busy, wrap} !== {3'd0, edec, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL post_reset_idle: got sel=%0d dec=%h busy=%b wrap=%b, exp sel=0 dec=01 busy=0 wrap=0",
                     sel, dec_out, busy, wrap);
        end
        n_tests++;
    endtask

    // ------------------------------------------------------- main
    initial begin
        n_tests    = 0;
        n_fail     = 0;
        sys_rst_n  = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        dir        = 1'b0;
        bounce     = 1'b0;
        sel_load   = 1'b0;
        sel_init   = 3'd0;
        z_start    = 1'b0;
        z_stop     = 1'b0;
        z_dir      = 1'b0;
        z_bounce   = 1'b0;
        z_sel_load = 1'b0;
        z_sel_init = 3'd0;
        repeat (3) tick();
        test_reset();
        sys_rst_n = 1'b1;
        tick();
        test_reset();

        test_up_scan();
        test_dir_down();
        test_hold_resume();
        test_load();
        test_fast_scan();
        test_async_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
